// File: rtl/mag_compare_tracker_4bit_pkg.sv
// Shared types for the magnitude-compare tracker: outcome encoding, operand width, buffer state.
package mag_compare_pkg;

  localparam int OPND_W = 4;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_LT   = 2'b01,
    RES_EQ   = 2'b10,
    RES_GT   = 2'b11
  } cmp_result_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

  // gt wins over eq, eq over lt; no flag at all means no outcome
  function automatic cmp_result_t encode_flags(input logic lt, input logic eq, input logic gt);
    if (gt)      return RES_GT;
    else if (eq) return RES_EQ;
    else if (lt) return RES_LT;
    else         return RES_NONE;
  endfunction

  function automatic logic flags_onehot(input logic lt, input logic eq, input logic gt);
    return (lt & ~eq & ~gt) | (~lt & eq & ~gt) | (~lt & ~eq & gt);
  endfunction

endpackage

// File: rtl/mag_compare_tracker_4bit_if.sv
// Comparison input and one-entry result output of the tracker, both valid/ready.
interface mag_compare_tracker_4bit_if;
  import mag_compare_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [OPND_W-1:0]     A;
  logic [OPND_W-1:0]     B;
  logic                  A_lt_B;
  logic                  A_eq_B;
  logic                  A_gt_B;
  logic                  out_valid;
  logic                  out_ready;
  cmp_result_t           out_result;
  logic [OPND_W-1:0]     out_winner;

  modport master (
    output in_valid, A, B, A_lt_B, A_eq_B, A_gt_B, out_ready,
    input  in_ready, out_valid, out_result, out_winner
  );

  modport slave (
    input  in_valid, A, B, A_lt_B, A_eq_B, A_gt_B, out_ready,
    output in_ready, out_valid, out_result, out_winner
  );

endinterface

// File: rtl/mag_compare_tracker_4bit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mag_compare_tracker_4bit.sv
// Comparator result tracker: one-entry output buffer, saturating outcome counts, running max.
// Optional one-hot flag checking is enabled by defining MAG_TRACK_ONEHOT_CHECK_EN.
module mag_compare_tracker_4bit
  import mag_compare_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clock,
  input  logic                reset_b,
  input  logic                clear,
  mag_compare_tracker_4bit_if.slave bus,
  output logic [CNT_W-1:0]    lt_count,
  output logic [CNT_W-1:0]    eq_count,
  output logic [CNT_W-1:0]    gt_count,
  output logic [OPND_W-1:0]   max_val,
  output logic                max_valid,
  output logic                flag_err,
  output buf_state_t          fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  // in_ready is high when the buffer is empty or is being drained this same cycle.
  buf_state_t          state_q, state_d;
  logic                in_ready_c;
  logic                accept;
  cmp_result_t         res_in;
  logic [OPND_W-1:0]   winner_in;
  cmp_result_t         result_q;
  logic [OPND_W-1:0]   winner_q;
  logic                stats_upd;

  assign res_in    = encode_flags(bus.A_lt_B, bus.A_eq_B, bus.A_gt_B);
  assign winner_in = bus.A_gt_B ? bus.A : (bus.A_lt_B ? bus.B : bus.A);
  assign stats_upd = accept && !clear;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_c = (state_q == ST_EMPTY) || bus.out_ready;
    accept     = bus.in_valid && in_ready_c;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready && !accept) state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      result_q <= RES_NONE;
      winner_q <= '0;
    end else if (accept) begin
      result_q <= res_in;
      winner_q <= winner_in;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = (state_q == ST_FULL);
  assign bus.out_result = result_q;
  assign bus.out_winner = winner_q;
  assign fsm_state      = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
    .clock(clock), .reset_b(reset_b), .clear(clear),
    .inc(stats_upd && (res_in == RES_LT)), .count(lt_count)
  );
  sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .clock(clock), .reset_b(reset_b), .clear(clear),
    .inc(stats_upd && (res_in == RES_EQ)), .count(eq_count)
  );
  sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
    .clock(clock), .reset_b(reset_b), .clear(clear),
    .inc(stats_upd && (res_in == RES_GT)), .count(gt_count)
  );

  // The very first accepted winner seeds max_val, even when it is 0
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      max_val   <= '0;
      max_valid <= 1'b0;
    end else if (clear) begin
      max_val   <= '0;
      max_valid <= 1'b0;
    end else if (accept && (!max_valid || (winner_in > max_val))) begin
      max_val   <= winner_in;
      max_valid <= 1'b1;
    end
  end

`ifdef MAG_TRACK_ONEHOT_CHECK_EN
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      flag_err <= 1'b0;
    end else if (clear) begin
      flag_err <= 1'b0;
    end else if (accept && !flags_onehot(bus.A_lt_B, bus.A_eq_B, bus.A_gt_B)) begin
      flag_err <= 1'b1;
    end
  end
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_mag_compare_tracker_4bit.sv
// Directed bench for mag_compare_tracker_4bit; a second CNT_W=2 instance mirrors the stimulus.
module tb_mag_compare_tracker_4bit;
  import mag_compare_pkg::*;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       lt;
    logic       eq;
    logic       gt;
    logic [1:0] exp_res;
    logic [3:0] exp_win;
  } vec_t;

  logic clock;
  logic reset_b;
  logic clear;

  mag_compare_tracker_4bit_if bus1 ();
  mag_compare_tracker_4bit_if bus2 ();

  logic [7:0] lt_count, eq_count, gt_count;
  logic [1:0] lt_count2, eq_count2, gt_count2;
  logic [3:0] max_val, max_val2;
  logic       max_valid, max_valid2, flag_err, flag_err2;
  buf_state_t fsm_state, fsm_state2;

  int n_checks = 0;
  int n_err    = 0;

  int exp_lt, exp_eq, exp_gt, exp_eq2, exp_max;
  logic exp_mv, exp_err;

  vec_t vecs [8];

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  mag_compare_tracker_4bit #(.CNT_W(8)) dut (
    .clock(clock), .reset_b(reset_b), .clear(clear), .bus(bus1.slave),
    .lt_count(lt_count), .eq_count(eq_count), .gt_count(gt_count),
    .max_val(max_val), .max_valid(max_valid), .flag_err(flag_err), .fsm_state(fsm_state)
  );

  mag_compare_tracker_4bit #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset_b(reset_b), .clear(clear), .bus(bus2.slave),
    .lt_count(lt_count2), .eq_count(eq_count2), .gt_count(gt_count2),
    .max_val(max_val2), .max_valid(max_valid2), .flag_err(flag_err2), .fsm_state(fsm_state2)
  );

  assign bus2.in_valid  = bus1.in_valid;
  assign bus2.A         = bus1.A;
  assign bus2.B         = bus1.B;
  assign bus2.A_lt_B    = bus1.A_lt_B;
  assign bus2.A_eq_B    = bus1.A_eq_B;
  assign bus2.A_gt_B    = bus1.A_gt_B;
  assign bus2.out_ready = bus1.out_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // driver
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic lt, input logic eq, input logic gt, input logic ordy);
    bus1.in_valid  = v;
    bus1.A         = a;
    bus1.B         = b;
    bus1.A_lt_B    = lt;
    bus1.A_eq_B    = eq;
    bus1.A_gt_B    = gt;
    bus1.out_ready = ordy;
  endtask

  task automatic model_clear();
    exp_lt = 0; exp_eq = 0; exp_gt = 0; exp_eq2 = 0; exp_max = 0;
    exp_mv = 1'b0; exp_err = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_lt_count"}, 32'(lt_count), 32'(exp_lt));
    check({tag, "_eq_count"}, 32'(eq_count), 32'(exp_eq));
    check({tag, "_gt_count"}, 32'(gt_count), 32'(exp_gt));
    check({tag, "_eq_count_w2"}, 32'(eq_count2), 32'(exp_eq2));
    check({tag, "_max_val"}, 32'(max_val), 32'(exp_max));
    check({tag, "_max_valid"}, 32'(max_valid), 32'(exp_mv));
    check({tag, "_flag_err"}, 32'(flag_err), 32'(exp_err));
  endtask

  // scoreboard for one accepted vector with out_ready held high
  task automatic apply_vec(input string tag, input vec_t v);
    drive(1'b1, v.a, v.b, v.lt, v.eq, v.gt, 1'b1);
    check({tag, "_in_ready_pre"}, 32'(bus1.in_ready), 32'd1);
    step();
    case (v.exp_res)
      2'b01: if (exp_lt < 255) exp_lt++;
      2'b10: begin
        if (exp_eq < 255) exp_eq++;
        if (exp_eq2 < 3) exp_eq2++;
      end
      2'b11: if (exp_gt < 255) exp_gt++;
      default: ;
    endcase
    if (!exp_mv || (int'(v.exp_win) > exp_max)) begin
      exp_max = int'(v.exp_win);
      exp_mv  = 1'b1;
    end
`ifdef MAG_TRACK_ONEHOT_CHECK_EN
    if ((int'(v.lt) + int'(v.eq) + int'(v.gt)) != 1) exp_err = 1'b1;
`endif
    check({tag, "_out_valid"}, 32'(bus1.out_valid), 32'd1);
    check({tag, "_out_result"}, 32'(bus1.out_result), 32'(v.exp_res));
    check({tag, "_out_winner"}, 32'(bus1.out_winner), 32'(v.exp_win));
    check_stats(tag);
  endtask

  initial begin
    vecs[0] = '{a: 4'd8,  b: 4'd1,  lt: 1'b0, eq: 1'b0, gt: 1'b1, exp_res: 2'b11, exp_win: 4'd8};
    vecs[1] = '{a: 4'd0,  b: 4'd0,  lt: 1'b0, eq: 1'b1, gt: 1'b0, exp_res: 2'b10, exp_win: 4'd0};
    vecs[2] = '{a: 4'd8,  b: 4'd1,  lt: 1'b0, eq: 1'b0, gt: 1'b1, exp_res: 2'b11, exp_win: 4'd8};
    vecs[3] = '{a: 4'd8,  b: 4'd1,  lt: 1'b0, eq: 1'b0, gt: 1'b1, exp_res: 2'b11, exp_win: 4'd8};
    vecs[4] = '{a: 4'd8,  b: 4'd15, lt: 1'b1, eq: 1'b0, gt: 1'b0, exp_res: 2'b01, exp_win: 4'd15};
    vecs[5] = '{a: 4'd5,  b: 4'd9,  lt: 1'b1, eq: 1'b0, gt: 1'b0, exp_res: 2'b01, exp_win: 4'd9};
    vecs[6] = '{a: 4'd7,  b: 4'd7,  lt: 1'b0, eq: 1'b1, gt: 1'b0, exp_res: 2'b10, exp_win: 4'd7};
    vecs[7] = '{a: 4'd3,  b: 4'd3,  lt: 1'b0, eq: 1'b0, gt: 1'b0, exp_res: 2'b00, exp_win: 4'd3};

    reset_b = 1'b0;
    clear   = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_clear();
    step();
    step();
    check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    check("rst_out_result", 32'(bus1.out_result), 32'd0);
    check("rst_out_winner", 32'(bus1.out_winner), 32'd0);
    check_stats("rst");
    reset_b = 1'b1;

    // back-to-back table, no bubbles
    for (int i = 0; i < 8; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("drain_out_valid", 32'(bus1.out_valid), 32'd0);
    check("drain_in_ready", 32'(bus1.in_ready), 32'd1);

    // saturation of the CNT_W=2 instance
    for (int i = 0; i < 5; i++)
      apply_vec($sformatf("sat%0d", i),
                '{a: 4'd4, b: 4'd4, lt: 1'b0, eq: 1'b1, gt: 1'b0, exp_res: 2'b10, exp_win: 4'd4});
    check("sat_eq_count_w2_final", 32'(eq_count2), 32'd3);

    // clear alone
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    check_stats("clr");

    // backpressure
    drive(1'b1, 4'd1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("bp_out_result", 32'(bus1.out_result), 32'b01);
    drive(1'b1, 4'd9, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_in_ready", i), 32'(bus1.in_ready), 32'd0);
      step();
      check($sformatf("bp%0d_out_valid", i), 32'(bus1.out_valid), 32'd1);
      check($sformatf("bp%0d_out_winner", i), 32'(bus1.out_winner), 32'd15);
      check($sformatf("bp%0d_lt_count", i), 32'(lt_count), 32'd1);
      check($sformatf("bp%0d_gt_count", i), 32'(gt_count), 32'd0);
    end
    bus1.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus1.in_ready), 32'd1);
    step();
    check("bp_release_result", 32'(bus1.out_result), 32'b11);
    check("bp_release_winner", 32'(bus1.out_winner), 32'd9);
    check("bp_release_gt_count", 32'(gt_count), 32'd1);
    check("bp_release_max", 32'(max_val), 32'd15);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("bp_drain_out_valid", 32'(bus1.out_valid), 32'd0);

    // clear coinciding with an accept
    drive(1'b1, 4'd12, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clracc_out_valid", 32'(bus1.out_valid), 32'd1);
    check("clracc_out_result", 32'(bus1.out_result), 32'b11);
    check("clracc_out_winner", 32'(bus1.out_winner), 32'd12);
    check_stats("clracc");

    // non-one-hot flags 011 (lt=0, eq=1, gt=1)
    drive(1'b1, 4'd6, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    check("oh_out_result", 32'(bus1.out_result), 32'b11);
    check("oh_out_winner", 32'(bus1.out_winner), 32'd6);
    check("oh_gt_count", 32'(gt_count), 32'd1);
    check("oh_max_val", 32'(max_val), 32'd6);
`ifdef MAG_TRACK_ONEHOT_CHECK_EN
    check("oh_flag_err", 32'(flag_err), 32'd1);
`else
    check("oh_flag_err", 32'(flag_err), 32'd0);
`endif
    drive(1'b1, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check("oh2_lt_count", 32'(lt_count), 32'd1);
    check("oh2_max_val", 32'(max_val), 32'd6);
`ifdef MAG_TRACK_ONEHOT_CHECK_EN
    check("oh2_flag_err_sticky", 32'(flag_err), 32'd1);
`else
    check("oh2_flag_err_sticky", 32'(flag_err), 32'd0);
`endif

    // async reset while a result is pending
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("pend_out_valid", 32'(bus1.out_valid), 32'd1);
    #3;
    reset_b = 1'b0;
    #1;
    model_clear();
    check("arst_out_valid", 32'(bus1.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus1.in_ready), 32'd1);
    check("arst_out_result", 32'(bus1.out_result), 32'd0);
    check("arst_out_winner", 32'(bus1.out_winner), 32'd0);
    check_stats("arst");
    #2;
    reset_b = 1'b1;
    step();
    check("post_rst_out_valid", 32'(bus1.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mag_compare_tracker_4bit.md
# mag_compare_tracker_4bit

Downstream consumer of the 4-bit dataflow magnitude comparator. Each cycle it can accept one comparison: operands A, B and the flags A_lt_B, A_eq_B, A_gt_B. It registers the result into a one-entry output buffer with a valid/ready handshake, keeps saturating counts of lt/eq/gt outcomes, and tracks the running maximum of the larger operand. A sticky error flag catches non-one-hot comparator flags.

## Interface
- CNT_W, default 8: width of each outcome counter.
- clock  input  1  rising-edge system clock
- reset_b  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of counters, max and error; does not touch the output buffer
- in_valid  input  1  comparison presented this cycle
- in_ready  output  1  block can accept this cycle
- A, B  input  4 each  operands fed to the comparator
- A_lt_B, A_eq_B, A_gt_B  input  1 each  comparator flags for A and B
- out_valid  output  1  out_result/out_winner hold a result
- out_ready  input  1  downstream takes the result
- out_result  output  2  encoded outcome: 01 lt, 10 eq, 11 gt, 00 none
- out_winner  output  4  larger operand; A when equal
- lt_count, eq_count, gt_count  output  CNT_W each  saturating outcome counts
- max_val  output  4  largest out_winner accepted since reset/clear
- max_valid  output  1  max_val holds a real value
- flag_err  output  1  sticky: flags seen not one-hot (macro-dependent)

## Operation
- Reset behaviour: all outputs are 0 during and after reset_b low, except in_ready, which is 1.
- Two-state FSM:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = (state==EMPTY) || out_ready. The block accepts a comparison when in_valid && in_ready.
- Transitions:
  - EMPTY + accept → FULL.
  - FULL + out_ready + accept → FULL, buffer reloaded (back-to-back, no bubble).
  - FULL + out_ready + no accept → EMPTY.
  - FULL + !out_ready → FULL; out_result and out_winner are held stable.
- On accept:
  - out_result = encode(flags). Priority is gt > eq > lt. All flags zero encodes 00.
  - out_winner = A_gt_B ? A : (A_lt_B ? B : A).
- Counters:
  - The counter matching the encoded outcome increments by 1.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - Outcome 00 increments nothing.
- Running max:
  - If !max_valid or out_winner > max_val (unsigned), then max_val ← winner and max_valid ← 1.
- clear vs accept:
  - clear has priority over the statistics update.
  - clear in the same cycle as an accept: counters, max and flag_err go to 0. The accepted result still enters the output buffer but is not counted.
- Reset mid-operation: an asynchronous drop of reset_b empties the buffer immediately. Any pending result is discarded.

## Timing
- Latency is 1 cycle: a result accepted at edge N is visible on out_* and in the statistics after edge N.
- Throughput is 1 result per cycle while out_ready=1.
- in_ready is combinational from state and out_ready. No other combinational input→output paths.
- Statistics outputs change only on accept or clear edges.

## Configuration
- Macro: MAG_TRACK_ONEHOT_CHECK_EN.
- Defined:
  - On accept, flag_err sets if the flags are not exactly one-hot.
  - flag_err is sticky until clear or reset.
- Undefined:
  - The check logic is absent and flag_err is tied to 0.
  - Priority encoding still applies.

## Structure
- Shared package mag_compare_pkg contains:
  - cmp_result_t encoding (RES_NONE=00, RES_LT=01, RES_EQ=10, RES_GT=11).
  - The 4-bit operand width constant.
- One natural sub-module, sat_counter: parameter CNT_W; ports clock, reset_b, clear, inc, count. It is instantiated three times.

## Test plan
- Reset, then one accept of A=8, B=1 with gt flag, out_ready=1:
  - out_result=11 and out_winner=8 one cycle later.
  - gt_count=1.
  - max_val=8, max_valid=1.
- Backpressure:
  - Accept A=1, B=15 (lt) with out_ready=0.
  - out_valid stays 1, out_winner stays 15, in_ready=0 for 5 cycles.
  - A second in_valid is not accepted and lt_count stays 1.
- Back-to-back: 4 accepts over 4 consecutive cycles with out_ready=1 (eq 0/0, gt 8/1, gt 8/1, lt 8/15):
  - No bubbles.
  - eq_count=1, gt_count=2, lt_count=1, max_val=15.
- Saturation with CNT_W=2: 5 eq accepts → eq_count=3.
- clear on the same cycle as a gt accept:
  - All counters are 0 and max_valid=0.
  - out_result=11 is still presented.
- Flags 011 on accept with the macro defined:
  - flag_err=1, out_result=11, gt_count increments.
  - Without the macro, flag_err stays 0.
  - A reset_b pulse mid-stream clears all outputs asynchronously.
